// File: rtl/mdrp_responder_if.sv
// MDRP bus bundle: opcode, address-increment and write data from the initiator, read data back.
interface mdrp_responder_if;
  logic [1:0] mdopc;
  logic       mdainc;
  logic [7:0] mdwdi;
  logic [7:0] mdrdo;

  modport master (output mdopc, output mdainc, output mdwdi, input mdrdo);
  modport slave  (input mdopc, input mdainc, input mdwdi, output mdrdo);
endinterface

// File: rtl/mdrp_responder.sv
// MDRP responder: 8-bit register bank behind an auto-incrementing pointer,
// plus a modelled PLL lock that drops on reset, pll_reset or any write.
module mdrp_responder #(
  parameter int ADDR_W      = 4,
  parameter int DEFAULT_FAC = 24,
  parameter int LOCK_DELAY  = 64
) (
  input  logic                        mdclk,
  input  logic                        rst_n,
  input  logic                        pll_reset,
  mdrp_responder_if.slave             bus,
  output logic [8*(2**ADDR_W)-1:0]    cfg,
  output logic                        lock,
  output logic                        busy
);

  localparam int DEPTH = 2**ADDR_W;

  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_READ  = 2'b10;
  localparam logic [1:0] OP_ALOAD = 2'b11;

  localparam logic [1:0] S_LOCKED = 2'd0;
  localparam logic [1:0] S_HOLD   = 2'd1;
  localparam logic [1:0] S_COUNT  = 2'd2;

  localparam logic [15:0] DELAY = 16'(LOCK_DELAY);
  localparam logic [7:0]  FAC   = 8'(DEFAULT_FAC);

  logic [ADDR_W-1:0]  r_addr;
  logic [8*DEPTH-1:0] r_bank;
  logic [7:0]         r_rdata;
  logic [1:0]         r_state;
  logic [15:0]        r_cnt;

  logic               w_write;
  logic               w_read;
  logic [ADDR_W-1:0]  w_addr_base;
  logic [ADDR_W-1:0]  w_addr_next;
  logic [ADDR_W+2:0]  w_bit_idx;

  assign w_write     = (bus.mdopc == OP_WRITE);
  assign w_read      = (bus.mdopc == OP_READ);
  // Increment applies after the op, so a load with mdainc lands on the loaded value + 1.
  assign w_addr_base = (bus.mdopc == OP_ALOAD) ? bus.mdwdi[ADDR_W-1:0] : r_addr;
  assign w_addr_next = w_addr_base + {{(ADDR_W-1){1'b0}}, bus.mdainc};
  assign w_bit_idx   = {r_addr, 3'b000};

  always_ff @(posedge mdclk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr  <= '0;
      r_bank  <= {{(8*DEPTH-8){1'b0}}, FAC};
      r_rdata <= '0;
    end else begin
      r_addr <= w_addr_next;
      if (w_write) begin
        r_bank[w_bit_idx +: 8] <= bus.mdwdi;
      end
      if (w_read) begin
        r_rdata <= r_bank[w_bit_idx +: 8];
      end
    end
  end

  // pll_reset outranks a write; a write in any other state (re)starts the full delay.
  always_ff @(posedge mdclk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_COUNT;
      r_cnt   <= DELAY;
    end else if (pll_reset) begin
      r_state <= S_HOLD;
      r_cnt   <= DELAY;
    end else if (w_write) begin
      r_state <= S_COUNT;
      r_cnt   <= DELAY;
    end else if (r_state != S_LOCKED) begin
      if (r_cnt <= 16'd1) begin
        r_state <= S_LOCKED;
      end else begin
        r_state <= S_COUNT;
        r_cnt   <= r_cnt - 16'd1;
      end
    end
  end

  assign cfg       = r_bank;
  assign bus.mdrdo = r_rdata;
  assign lock      = (r_state == S_LOCKED);
  assign busy      = (r_state != S_LOCKED);

endmodule
